// File: rtl/bf16_reduce_ctrl_pkg.sv
// Shared constants and state encoding for the BF16 sum-reduction controller.
// Contents: BF16 special encodings, default adder latency, FSM state enum.
package bf16_reduce_ctrl_pkg;

    localparam int unsigned BF16_W               = 16;
    localparam logic [15:0] BF16_ZERO            = 16'h0000;
    localparam logic [15:0] BF16_QNAN            = 16'h7FC0;
    localparam int unsigned BF16_ADD_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_REDUCE = 2'd1,
        ST_OUT    = 2'd2
    } red_state_e;

endpackage

// File: rtl/bf16_tag_pipe.sv
// Tag pipe: ADD_LAT-deep {valid, slot_id} shift register that advances every
// cycle in lock-step with the external adder, so the head names the slot the
// adder result currently on add_result belongs to.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset (clears all tags)
//   push_valid/id    tag entering the pipe (issue cycle)
//   head_valid/id    tag leaving the pipe (result cycle)
//   busy             any tag in flight, head included
module bf16_tag_pipe #(
    parameter int unsigned ADD_LAT = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_valid,
    input  logic [ID_W-1:0] push_id,
    output logic            head_valid,
    output logic [ID_W-1:0] head_id,
    output logic            busy
);

    logic [ADD_LAT-1:0] valid_q, valid_d;
    logic [ID_W-1:0]    id_q [ADD_LAT];
    logic [ID_W-1:0]    id_d [ADD_LAT];

    // Shift one stage per cycle; stage 0 takes the new tag.
    always_comb begin
        valid_d = {valid_q[ADD_LAT-2:0], push_valid};
        id_d[0] = push_id;
        for (int unsigned k = 1; k < ADD_LAT; k++) begin
            id_d[k] = id_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < ADD_LAT; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign head_valid = valid_q[ADD_LAT-1];
    assign head_id    = id_q[ADD_LAT-1];
    assign busy       = |valid_q;

endmodule

// File: rtl/bf16_reduce_ctrl.sv
// Streaming BF16 sum-reduction controller wrapped around an external
// ADD_LAT-cycle pipelined BF16 adder. Elements are accumulated round-robin into
// NSLOT partial-sum slots to hide adder latency; after in_last the live slots
// are folded pairwise through the same adder and the single sum is presented.
// Optional build macro: BF16_REDUCE_CNT_EN adds out_count[15:0], the saturating
// number of elements accepted in the packet, valid with out_valid.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_data/in_last   element stream
//   out_valid/out_ready/out_data        sum output (held until handshake)
//   add_a/add_b/add_sub/add_valid_in    adder issue (combinational)
//   add_result/add_valid_out            adder return
module bf16_reduce_ctrl
    import bf16_reduce_ctrl_pkg::*;
#(
    parameter int unsigned ADD_LAT = BF16_ADD_LAT_DEFAULT,
    parameter int unsigned NSLOT   = ADD_LAT + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BF16_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef BF16_REDUCE_CNT_EN
    output logic [15:0]       out_count,
`endif
    output logic [BF16_W-1:0] out_data,
    output logic [BF16_W-1:0] add_a,
    output logic [BF16_W-1:0] add_b,
    output logic              add_sub,
    output logic              add_valid_in,
    input  logic [BF16_W-1:0] add_result,
    input  logic              add_valid_out
);

    localparam int unsigned ID_W   = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int unsigned CNT_W  = $clog2(NSLOT + 1);
    localparam int unsigned WARM_W = $clog2(ADD_LAT + 1);

    red_state_e        state_q, state_d;
    logic [BF16_W-1:0] slot_q [NSLOT];
    logic [BF16_W-1:0] slot_d [NSLOT];
    logic [NSLOT-1:0]  resident_q, resident_d;
    logic [NSLOT-1:0]  live_q, live_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [BF16_W-1:0] out_data_q, out_data_d;
    logic [WARM_W-1:0] warm_q, warm_d;

    logic              head_valid;
    logic [ID_W-1:0]   head_id;
    logic              busy;
    logic [ID_W-1:0]   push_id;

    logic              have_i, have_j, have_k;
    logic [ID_W-1:0]   i_idx, j_idx, k_idx;
    logic [CNT_W-1:0]  live_cnt;
    logic              accept;
    logic              out_hs;

    assign accept = (state_q == ST_ACCUM) && in_valid && resident_q[ptr_q];
    assign out_hs = (state_q == ST_OUT) && out_ready;

    bf16_tag_pipe #(
        .ADD_LAT (ADD_LAT),
        .ID_W    (ID_W)
    ) u_tag_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (add_valid_in),
        .push_id    (push_id),
        .head_valid (head_valid),
        .head_id    (head_id),
        .busy       (busy)
    );

    // Fold-pair selection: lowest two live&&resident slots; lowest live slot
    // is the survivor once only one remains.
    always_comb begin
        have_i   = 1'b0;
        have_j   = 1'b0;
        have_k   = 1'b0;
        i_idx    = '0;
        j_idx    = '0;
        k_idx    = '0;
        live_cnt = '0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            if (live_q[k]) begin
                live_cnt = live_cnt + CNT_W'(1);
                if (!have_k) begin
                    have_k = 1'b1;
                    k_idx  = ID_W'(k);
                end
                if (resident_q[k]) begin
                    if (!have_i) begin
                        have_i = 1'b1;
                        i_idx  = ID_W'(k);
                    end else if (!have_j) begin
                        have_j = 1'b1;
                        j_idx  = ID_W'(k);
                    end
                end
            end
        end
    end

    // Next-state, slot bank update and adder issue.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        resident_d   = resident_q;
        live_d       = live_q;
        ptr_d        = ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        warm_d       = (warm_q == WARM_W'(ADD_LAT)) ? warm_q : warm_q + WARM_W'(1);
        in_ready     = 1'b0;
        add_a        = BF16_ZERO;
        add_b        = BF16_ZERO;
        add_valid_in = 1'b0;
        push_id      = '0;

        // Returning result lands in the slot named by the tag pipe head.
        if (head_valid) begin
            slot_d[head_id]     = add_result;
            resident_d[head_id] = 1'b1;
        end

        unique case (state_q)
            ST_ACCUM: begin
                // No bypass: a slot becomes usable the cycle after its result lands.
                in_ready = resident_q[ptr_q];
                if (accept) begin
                    add_a             = in_data;
                    add_b             = slot_q[ptr_q];
                    add_valid_in      = 1'b1;
                    push_id           = ptr_q;
                    resident_d[ptr_q] = 1'b0;
                    ptr_d             = (ptr_q == ID_W'(NSLOT - 1)) ? '0 : ptr_q + ID_W'(1);
                    if (in_last) begin
                        state_d = ST_REDUCE;
                    end
                end
            end
            ST_REDUCE: begin
                if (have_j) begin
                    add_a             = slot_q[i_idx];
                    add_b             = slot_q[j_idx];
                    add_valid_in      = 1'b1;
                    push_id           = i_idx;
                    resident_d[i_idx] = 1'b0;
                    live_d[j_idx]     = 1'b0;
                end else if ((live_cnt == CNT_W'(1)) && !busy && resident_q[k_idx]) begin
                    out_valid_d = 1'b1;
                    out_data_d  = slot_q[k_idx];
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    for (int unsigned k = 0; k < NSLOT; k++) begin
                        slot_d[k] = BF16_ZERO;
                    end
                    resident_d = '1;
                    live_d     = '1;
                    ptr_d      = '0;
                    state_d    = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            for (int unsigned k = 0; k < NSLOT; k++) begin
                slot_q[k] <= BF16_ZERO;
            end
            resident_q  <= '1;
            live_q      <= '1;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= BF16_ZERO;
            warm_q      <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            resident_q  <= resident_d;
            live_q      <= live_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            warm_q      <= warm_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign add_sub   = 1'b0;

`ifdef BF16_REDUCE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Element count per packet, saturating, cleared on output handshake.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (out_hs) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;
`endif

    // Results still draining from before a reset arrive with an empty tag pipe,
    // so the lock-step check is held off for ADD_LAT cycles after reset.
    a_tag_sync: assert property (@(posedge clk) disable iff (!rst_n || (warm_q != WARM_W'(ADD_LAT)))
        add_valid_out == head_valid)
        else $error("add_valid_out out of step with tag pipe head");

endmodule

// File: tb/tb_bf16_reduce_ctrl.sv
// Bench for bf16_reduce_ctrl: a behavioural BF16 adder (real arithmetic,
// RNE to BF16, canonical NaN) with ADD_LAT latency sits on the adder port;
// expected sums come from integer arithmetic or hand-computed literals.
module tb_bf16_reduce_ctrl;

    localparam int unsigned ADD_LAT   = 4;
    localparam int          LAT_LIMIT = 2 * ADD_LAT + 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_sub;
    logic        add_valid_in;
    logic [15:0] add_result;
    logic        add_valid_out;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q [$];
    int          hold_low = 0;
    logic [15:0] pkt [64];
    int          pkt_len;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data = '0;

    always #5 clk = ~clk;

    bf16_reduce_ctrl #(
        .ADD_LAT (ADD_LAT),
        .NSLOT   (ADD_LAT + 1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_sub       (add_sub),
        .add_valid_in  (add_valid_in),
        .add_result    (add_result),
        .add_valid_out (add_valid_out)
    );

    function automatic real bf16_to_real(input logic [15:0] h);
        int e;
        e = int'(h[14:7]);
        if (e == 255) begin
            if (h[6:0] != 7'd0) return $bitstoreal(64'h7FF8000000000000);
            return $bitstoreal({h[15], 63'h7FF0000000000000});
        end
        if (e == 0) return 0.0;
        return $bitstoreal({h[15], 11'(e - 127 + 1023), h[6:0], 45'h0});
    endfunction

    function automatic logic [15:0] real_to_bf16(input real r);
        logic [63:0] b;
        logic [8:0]  man;
        int          e;
        logic [15:0] res;
        b = $realtobits(r);
        e = int'(b[62:52]);
        if (e == 2047) begin
            res = (b[51:0] != 52'd0) ? 16'h7FC0 : {b[63], 15'h7F80};
        end else if (e == 0) begin
            res = {b[63], 15'h0000};
        end else begin
            e   = e - 1023 + 127;
            man = {2'b01, b[51:45]};
            if (b[44] && ((b[43:0] != 44'd0) || b[45])) man = man + 9'd1;
            if (man[8]) begin
                e   = e + 1;
                man = man >> 1;
            end
            if (e >= 255)     res = {b[63], 15'h7F80};
            else if (e <= 0)  res = {b[63], 15'h0000};
            else              res = {b[63], 8'(e), man[6:0]};
        end
        return res;
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        return real_to_bf16(bf16_to_real(a) + bf16_to_real(b));
    endfunction

    // Free-running adder model: not reset, so in-flight results survive a DUT reset.
    bit   [ADD_LAT-1:0] av_q = '0;
    logic [15:0]        ar_q [ADD_LAT];
    always @(posedge clk) begin
        av_q    <= {av_q[ADD_LAT-2:0], add_valid_in};
        ar_q[0] <= fadd(add_a, add_b);
        for (int k = 1; k < ADD_LAT; k++) ar_q[k] <= ar_q[k-1];
    end
    assign add_valid_out = av_q[ADD_LAT-1];
    assign add_result    = ar_q[ADD_LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output side: drives out_ready, checks every valid cycle against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
            out_ready = 1'b0;
        end else begin
            if (prev_hold) begin
                check("out_valid_held", 32'(out_valid), 32'd1);
                check("out_data_stable", 32'(out_data), 32'(prev_data));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_out: got 0x%0h with no packet outstanding", out_data);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q[0]));
                end
                check("in_ready_in_out", 32'(in_ready), 32'd0);
                if (hold_low > 0) begin
                    out_ready = 1'b0;
                    hold_low--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready && (exp_q.size() != 0)) void'(exp_q.pop_front());
                prev_hold = !out_ready;
                prev_data = out_data;
            end else begin
                out_ready = ($urandom_range(0, 1) != 0);
                prev_hold = 1'b0;
            end
        end
    end

    // Drive pkt[0..pkt_len-1]; stalls counts not-ready cycles after the first accept.
    task automatic send(input bit gaps, output int stalls);
        int w;
        bit started;
        started = 1'b0;
        stalls  = 0;
        for (int i = 0; i < pkt_len; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_last  = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_last  = (i == pkt_len - 1);
            w = 0;
            while (!in_ready && (w < 400)) begin
                if (started) stalls++;
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                check("in_ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            started = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0) && (w < 1000)) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stalls;
        int lat;
        int sum;
        int v;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_add_valid_in", 32'(add_valid_in), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        check("rst_add_sub", 32'(add_sub), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single element, with latency bound
        pkt[0] = 16'h3F80; pkt_len = 1;
        exp_q.push_back(16'h3F80);
        send(1'b0, stalls);
        lat = 0;
        while (!out_valid && (lat < 200)) begin
            @(negedge clk);
            lat++;
        end
        check("single_latency_within_bound", 32'(lat <= LAT_LIMIT), 32'd1);
        wait_drain();

        // 1+2+3+4
        pkt[0] = 16'h3F80; pkt[1] = 16'h4000; pkt[2] = 16'h4040; pkt[3] = 16'h4080; pkt_len = 4;
        exp_q.push_back(16'h4120);
        send(1'b0, stalls);
        wait_drain();

        // Five back-to-back ones at full rate
        for (int i = 0; i < 5; i++) pkt[i] = 16'h3F80;
        pkt_len = 5;
        exp_q.push_back(16'h40A0);
        send(1'b0, stalls);
        check("b2b_in_ready_stalls", 32'(stalls), 32'd0);
        wait_drain();

        // Backpressure for 10 cycles, then a following packet
        hold_low = 10;
        pkt[0] = 16'h4000; pkt[1] = 16'h4040; pkt_len = 2;
        exp_q.push_back(16'h40A0);
        send(1'b0, stalls);
        pkt[0] = 16'h3F80; pkt[1] = 16'h3F80; pkt[2] = 16'h4000; pkt_len = 3;
        exp_q.push_back(16'h4080);
        send(1'b0, stalls);
        wait_drain();
        check("hold_low_consumed", 32'(hold_low), 32'd0);

        // Special values
        pkt[0] = 16'h3F80; pkt[1] = 16'h7F80; pkt[2] = 16'hFF80; pkt_len = 3;
        exp_q.push_back(16'h7FC0);
        send(1'b0, stalls);
        pkt[0] = 16'h3F80; pkt[1] = 16'h7FC1; pkt[2] = 16'h4000; pkt_len = 3;
        exp_q.push_back(16'h7FC0);
        send(1'b0, stalls);
        wait_drain();

        // Reset during REDUCE with adder results still in flight
        pkt[0] = 16'h4000; pkt[1] = 16'h4040; pkt[2] = 16'h4080; pkt[3] = 16'h3F80; pkt[4] = 16'h4000;
        pkt_len = 5;
        send(1'b0, stalls);
        check("reduce_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", 32'(in_ready), 32'd1);
        pkt[0] = 16'h4000; pkt_len = 1;
        exp_q.push_back(16'h4000);
        send(1'b0, stalls);
        wait_drain();

        // Random integer-valued packets: every partial sum is exact in BF16
        for (int p = 0; p < 40; p++) begin
            pkt_len = $urandom_range(1, 16);
            sum = 0;
            for (int i = 0; i < pkt_len; i++) begin
                v      = $urandom_range(0, 15);
                sum   += v;
                pkt[i] = real_to_bf16(real'(v));
            end
            exp_q.push_back(real_to_bf16(real'(sum)));
            send(1'b1, stalls);
        end
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
